bist_sched: RTL and testbench

BIST_SCHED -- requirements
Module: bist_sched

---
 rtl/bist_pkg.sv | 6 +
 rtl/bist_prio_enc.sv | 15 +
 rtl/bist_sched.sv | 79 +++++++
 tb/tb_bist_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding and default sizing for the memory BIST scheduler
package bist_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, LAUNCH, WAIT, RECORD, FINISH} state_t;
  localparam int NUM_MEM_DEF = 4;
  localparam int TIMEOUT_DEF = 1024;
endpackage

// File: rtl/bist_prio_enc.sv
// bist_prio_enc: lowest-index set-bit encoder with valid flag
module bist_prio_enc #(
  parameter int W = 4
) (
  input  logic [W-1:0]         req,
  output logic [$clog2(W)-1:0] idx,
  output logic                 valid
);
  localparam int IW = $clog2(W);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) idx = req[i] ? IW'(i) : idx;
  end
  assign valid = |req;
endmodule

// File: rtl/bist_sched.sv
// bist_sched: walks a mask of memories through one shared BIST engine with a per-run watchdog
module bist_sched
  import bist_pkg::*;
#(
  parameter int NUM_MEM = NUM_MEM_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_MEM-1:0]         mem_mask,
  output logic                       eng_start,
  output logic [$clog2(NUM_MEM)-1:0] mem_sel,
  input  logic                       eng_done,
  input  logic                       eng_fail,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic [NUM_MEM-1:0]         fail_map,
  output logic                       timeout
);
  localparam int SW = $clog2(NUM_MEM);
  localparam int CW = $clog2(TIMEOUT);
  state_t             state, nxt;
  logic [NUM_MEM-1:0] pending;
  logic [CW-1:0]      cnt;
  logic [SW-1:0]      idx;
  logic               valid, accept, term;
  bist_prio_enc #(.W(NUM_MEM)) u_enc (.req(pending), .idx(idx), .valid(valid));
  assign accept = (state == IDLE || state == FINISH) && start;
  assign term   = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE, FINISH: nxt = start ? SELECT : state;
      SELECT:       nxt = valid ? LAUNCH : FINISH;
      LAUNCH:       nxt = WAIT;
      WAIT:         nxt = (eng_done || term) ? RECORD : WAIT;
      RECORD:       nxt = SELECT;
      default:      nxt = IDLE;
    endcase
  end
  always_comb begin
    eng_start = state == LAUNCH;
    busy      = state inside {SELECT, LAUNCH, WAIT, RECORD};
    done      = state == FINISH;
    fail      = done && |fail_map;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      fail_map <= '0;
      timeout  <= 1'b0;
      mem_sel  <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        pending  <= mem_mask;
        fail_map <= '0;
        timeout  <= 1'b0;
      end
      if (state == SELECT && valid) mem_sel <= idx;
      if (state == LAUNCH) cnt <= '0;
      // a response on the terminal-count cycle wins over the watchdog
      if (state == WAIT) begin
        if (eng_done) fail_map[mem_sel] <= eng_fail;
        else if (term) begin
          fail_map[mem_sel] <= 1'b1;
          timeout           <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end
      if (state == RECORD) pending[mem_sel] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bist_sched.sv
// tb_bist_sched: directed scenario tests for bist_sched (short and default watchdog instances)
module tb_bist_sched;
  logic       clk = 1'b0;
  logic       rst, start, eng_done, eng_fail;
  logic [3:0] mem_mask;
  logic       eng_start, busy, done, fail, timeout;
  logic [1:0] mem_sel;
  logic [3:0] fail_map;
  logic       l_eng_start, l_busy, l_done, l_fail, l_timeout;
  logic [1:0] l_mem_sel;
  logic [3:0] l_fail_map;
  int vec = 0, err = 0, cyc = 0, sp = 0, lsp = 0;

  bist_sched #(.NUM_MEM(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_mask(mem_mask), .eng_start(eng_start),
    .mem_sel(mem_sel), .eng_done(eng_done), .eng_fail(eng_fail), .busy(busy), .done(done),
    .fail(fail), .fail_map(fail_map), .timeout(timeout));

  bist_sched #(.NUM_MEM(4), .TIMEOUT(1024)) dut_l (
    .clk(clk), .rst(rst), .start(start), .mem_mask(mem_mask), .eng_start(l_eng_start),
    .mem_sel(l_mem_sel), .eng_done(eng_done), .eng_fail(eng_fail), .busy(l_busy), .done(l_done),
    .fail(l_fail), .fail_map(l_fail_map), .timeout(l_timeout));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (eng_start) sp++;
    if (l_eng_start) lsp++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; eng_done = 1'b0; eng_fail = 1'b0; mem_mask = 4'b0;
    tick;
    rst = 1'b0;
    tick;
  endtask

  // Drives one session; engine answers lat cycles after each launch (lat<0: never)
  task automatic session(input logic [3:0] mask, input int lat, input logic [3:0] fmask,
                         input bit lng, input bit rep, output int np, output logic [7:0] seq,
                         output int cycles, output bit hung);
    int c0, s0, k;
    logic es, dn;
    logic [1:0] ms;
    hung = 1'b0; seq = '0; k = 0;
    c0 = cyc; s0 = lng ? lsp : sp;
    mem_mask = mask; start = 1'b1;
    tick;
    start = 1'b0;
    while (1) begin
      es = lng ? l_eng_start : eng_start;
      dn = lng ? l_done : done;
      ms = lng ? l_mem_sel : mem_sel;
      if (dn) break;
      if (k >= 1200) begin hung = 1'b1; break; end
      if (es) begin
        seq = {seq[5:0], ms};
        if (rep) begin start = 1'b1; mem_mask = 4'b1111; end
        if (lat >= 0) begin
          repeat (lat) begin tick; start = 1'b0; end
          eng_done = 1'b1; eng_fail = fmask[ms];
          tick;
          eng_done = 1'b0; eng_fail = 1'b0; start = 1'b0;
        end else begin
          tick;
          start = 1'b0;
        end
      end else tick;
      k++;
    end
    cycles = cyc - c0;
    np = (lng ? lsp : sp) - s0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; eng_done = 1'b0; eng_fail = 1'b0; mem_mask = 4'b0;
    #1;
    vec++; if ({busy, done, fail, eng_start, timeout, fail_map, mem_sel} !== 11'd0) begin
      err++; $display("FAIL reset_async got %b exp 0", {busy, done, fail, eng_start, timeout, fail_map, mem_sel}); end
    tick;
    vec++; if ({l_busy, l_done, l_fail, l_eng_start, l_timeout, l_fail_map, l_mem_sel} !== 11'd0) begin
      err++; $display("FAIL reset_long got %b exp 0", {l_busy, l_done, l_fail, l_eng_start, l_timeout, l_fail_map, l_mem_sel}); end
    rst = 1'b0;
    tick;
    vec++; if ({busy, done} !== 2'b00) begin
      err++; $display("FAIL reset_idle got %b exp 00", {busy, done}); end
  endtask

  task automatic test_walk;
    int np, cy; logic [7:0] seq; bit hung;
    do_reset;
    session(4'b1011, 20, 4'b0000, 1'b1, 1'b0, np, seq, cy, hung);
    vec++; if (hung) begin err++; $display("FAIL walk_hang got done=%b exp 1", l_done); end
    vec++; if (np !== 3) begin err++; $display("FAIL walk_pulses got %0d exp 3", np); end
    vec++; if (seq !== 8'h07) begin err++; $display("FAIL walk_sel_seq got %h exp 07", seq); end
    vec++; if (cy !== 71) begin err++; $display("FAIL walk_latency got %0d exp 71", cy); end
    vec++; if ({l_busy, l_done, l_fail, l_timeout, l_fail_map} !== 8'b0100_0000) begin
      err++; $display("FAIL walk_result got %b exp 01000000", {l_busy, l_done, l_fail, l_timeout, l_fail_map}); end
    repeat (3) tick;
    vec++; if ({l_done, l_fail_map} !== 5'b1_0000) begin
      err++; $display("FAIL walk_hold got %b exp 10000", {l_done, l_fail_map}); end
  endtask

  task automatic test_fail;
    int np, cy; logic [7:0] seq; bit hung;
    do_reset;
    session(4'b0110, 3, 4'b0100, 1'b0, 1'b0, np, seq, cy, hung);
    vec++; if (hung || np !== 2) begin err++; $display("FAIL fail_pulses got %0d hung=%b exp 2", np, hung); end
    vec++; if (seq !== 8'h06) begin err++; $display("FAIL fail_sel_seq got %h exp 06", seq); end
    vec++; if ({busy, done, fail, timeout, fail_map} !== 8'b0110_0100) begin
      err++; $display("FAIL fail_result got %b exp 01100100", {busy, done, fail, timeout, fail_map}); end
  endtask

  task automatic test_timeout;
    int np, cy; logic [7:0] seq; bit hung;
    do_reset;
    session(4'b0001, -1, 4'b0000, 1'b0, 1'b0, np, seq, cy, hung);
    vec++; if (hung || np !== 1) begin err++; $display("FAIL to_pulses got %0d hung=%b exp 1", np, hung); end
    vec++; if (cy !== 21) begin err++; $display("FAIL to_latency got %0d exp 21", cy); end
    vec++; if ({busy, done, fail, timeout, fail_map} !== 8'b0111_0001) begin
      err++; $display("FAIL to_result got %b exp 01110001", {busy, done, fail, timeout, fail_map}); end
  endtask

  // Restarts from FINISH of the timeout session, so stale flags must clear
  task automatic test_zero;
    int np, cy; logic [7:0] seq; bit hung;
    session(4'b0000, 0, 4'b0000, 1'b0, 1'b0, np, seq, cy, hung);
    vec++; if (hung || cy !== 2) begin err++; $display("FAIL zero_latency got %0d hung=%b exp 2", cy, hung); end
    vec++; if (np !== 0) begin err++; $display("FAIL zero_pulses got %0d exp 0", np); end
    vec++; if ({busy, done, fail, timeout, fail_map} !== 8'b0100_0000) begin
      err++; $display("FAIL zero_result got %b exp 01000000", {busy, done, fail, timeout, fail_map}); end
  endtask

  task automatic test_reset_mid;
    int np, cy; logic [7:0] seq; bit hung;
    do_reset;
    mem_mask = 4'b0010; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    vec++; if ({busy, mem_sel} !== 3'b1_01) begin
      err++; $display("FAIL mid_wait got %b exp 101", {busy, mem_sel}); end
    #2 rst = 1'b1;
    #1;
    vec++; if ({busy, done, fail, eng_start, timeout, fail_map, mem_sel} !== 11'd0) begin
      err++; $display("FAIL mid_async got %b exp 0", {busy, done, fail, eng_start, timeout, fail_map, mem_sel}); end
    tick;
    rst = 1'b0;
    repeat (3) tick;
    vec++; if ({busy, done} !== 2'b00) begin
      err++; $display("FAIL mid_abort got %b exp 00", {busy, done}); end
    session(4'b0010, 3, 4'b0000, 1'b0, 1'b0, np, seq, cy, hung);
    vec++; if (hung || np !== 1 || seq !== 8'h01) begin
      err++; $display("FAIL mid_rerun got np=%0d seq=%h exp np=1 seq=01", np, seq); end
    vec++; if ({busy, done, fail, timeout, fail_map} !== 8'b0100_0000) begin
      err++; $display("FAIL mid_result got %b exp 01000000", {busy, done, fail, timeout, fail_map}); end
  endtask

  task automatic test_back_to_back;
    int np, cy; logic [7:0] seq; bit hung;
    do_reset;
    session(4'b0001, 16, 4'b0001, 1'b0, 1'b1, np, seq, cy, hung);
    vec++; if (hung || np !== 1) begin err++; $display("FAIL b2b_pulses got %0d hung=%b exp 1", np, hung); end
    vec++; if (cy !== 21) begin err++; $display("FAIL b2b_latency got %0d exp 21", cy); end
    vec++; if ({busy, done, fail, timeout, fail_map} !== 8'b0110_0001) begin
      err++; $display("FAIL b2b_result got %b exp 01100001", {busy, done, fail, timeout, fail_map}); end
  endtask

  initial begin
    test_reset;
    test_walk;
    test_fail;
    test_timeout;
    test_zero;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
